// File: rtl/mouse_receiver_if.sv
// PS/2 receiver bus bundle.
//   CLK_MOUSE_IN    raw PS/2 clock line (asynchronous)
//   DATA_MOUSE_IN   raw PS/2 data line (asynchronous)
//   READ_ENABLE     reception allowed when high
//   BYTE_READY      one-cycle pulse, frame complete
//   BYTE_READ       received data byte
//   BYTE_ERROR_CODE bit0 = parity error, bit1 = stop-bit error
// master: the side driving the lines and consuming bytes; slave: the receiver.
interface mouse_receiver_if;
  logic       CLK_MOUSE_IN;
  logic       DATA_MOUSE_IN;
  logic       READ_ENABLE;
  logic       BYTE_READY;
  logic [7:0] BYTE_READ;
  logic [1:0] BYTE_ERROR_CODE;

  modport master (
    output CLK_MOUSE_IN,
    output DATA_MOUSE_IN,
    output READ_ENABLE,
    input  BYTE_READY,
    input  BYTE_READ,
    input  BYTE_ERROR_CODE
  );

  modport slave (
    input  CLK_MOUSE_IN,
    input  DATA_MOUSE_IN,
    input  READ_ENABLE,
    output BYTE_READY,
    output BYTE_READ,
    output BYTE_ERROR_CODE
  );
endinterface

// File: rtl/mouse_receiver.sv
// PS/2 device-to-host receiver. Synchronises and glitch-filters the PS/2
// clock, deserialises 11-bit frames (start, 8 data LSB first, odd parity,
// stop) and presents each byte with an error code and a one-cycle strobe.
// Ports:
//   CLK    system clock
//   RESET  asynchronous active-low reset
//   bus    mouse_receiver_if.slave (PS/2 lines, READ_ENABLE, byte outputs)
module mouse_receiver #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100_000
) (
  input logic              CLK,
  input logic              RESET,
  mouse_receiver_if.slave  bus
);

  localparam int unsigned FC_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILTER_LEN - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_DONE
  } state_t;

  state_t          state;
  logic            clk_s1, clk_s2;
  logic            dat_s1, dat_s2;
  logic            filt;
  logic [FC_W-1:0] fcnt;
  logic            fall_c;
  logic [2:0]      bit_cnt;
  logic [TO_W-1:0] to_cnt;
  logic [7:0]      shreg;
  logic            par_q;
  logic            stop_q;
  logic            byte_ready_q;
  logic [7:0]      byte_read_q;
  logic [1:0]      err_q;

  // Two-flop synchronisers for both PS/2 lines (idle high).
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= bus.CLK_MOUSE_IN;
      clk_s2 <= clk_s1;
      dat_s1 <= bus.DATA_MOUSE_IN;
      dat_s2 <= dat_s1;
    end
  end

  // Glitch filter: level flips after FILTER_LEN consecutive disagreeing samples.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      filt <= 1'b1;
      fcnt <= '0;
    end else if (clk_s2 == filt) begin
      fcnt <= '0;
    end else if (fcnt == FC_LAST) begin
      filt <= clk_s2;
      fcnt <= '0;
    end else begin
      fcnt <= fcnt + FC_W'(1);
    end
  end

  // Falling edge: the filter is about to flip from 1 to 0 this cycle.
  assign fall_c = filt && !clk_s2 && (fcnt == FC_LAST);

  // Frame state machine with registered outputs.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state        <= S_IDLE;
      bit_cnt      <= '0;
      to_cnt       <= '0;
      shreg        <= '0;
      par_q        <= 1'b0;
      stop_q       <= 1'b0;
      byte_ready_q <= 1'b0;
      byte_read_q  <= '0;
      err_q        <= '0;
    end else begin
      byte_ready_q <= 1'b0;
      // DONE always completes; elsewhere a dropped enable aborts the frame.
      if (!bus.READ_ENABLE && (state != S_DONE)) begin
        state   <= S_IDLE;
        bit_cnt <= '0;
        to_cnt  <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            bit_cnt <= '0;
            to_cnt  <= '0;
            if (fall_c && !dat_s2) begin
              state <= S_DATA;
            end
          end
          S_DATA, S_PARITY, S_STOP: begin
            // A falling edge takes priority over an expiring timeout.
            if (fall_c) begin
              to_cnt <= '0;
              if (state == S_DATA) begin
                shreg[bit_cnt] <= dat_s2;
                bit_cnt        <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                  state <= S_PARITY;
                end
              end else if (state == S_PARITY) begin
                par_q <= dat_s2;
                state <= S_STOP;
              end else begin
                stop_q <= dat_s2;
                state  <= S_DONE;
              end
            end else if (to_cnt == TO_LAST) begin
              state   <= S_IDLE;
              to_cnt  <= '0;
              bit_cnt <= '0;
            end else begin
              to_cnt <= to_cnt + TO_W'(1);
            end
          end
          S_DONE: begin
            byte_read_q  <= shreg;
            // Odd parity: error when data plus parity holds an even count of ones.
            err_q        <= {~stop_q, ~(^shreg ^ par_q)};
            byte_ready_q <= 1'b1;
            state        <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.BYTE_READY      = byte_ready_q;
  assign bus.BYTE_READ       = byte_read_q;
  assign bus.BYTE_ERROR_CODE = err_q;

endmodule

// File: tb/tb_mouse_receiver.sv
// Directed bench for mouse_receiver: valid frames, parity/stop errors,
// timeout, READ_ENABLE abort, clock glitches, async reset, back-to-back.
module tb_mouse_receiver;

  localparam int unsigned FLEN = 8;
  localparam int unsigned TOUT = 300;
  localparam int          HP   = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  mouse_receiver_if bus ();

  mouse_receiver #(
    .FILTER_LEN     (FLEN),
    .TIMEOUT_CYCLES (TOUT)
  ) dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus)
  );

  int   checks = 0;
  int   failures = 0;
  int   ready_cnt = 0;
  int   consec = 0;
  logic prev_ready = 1'b0;

  // Pulse counter and back-to-back strobe detector.
  always @(negedge clk) begin
    if (bus.BYTE_READY === 1'b1) begin
      ready_cnt = ready_cnt + 1;
      if (prev_ready) consec = consec + 1;
    end
    prev_ready = (bus.BYTE_READY === 1'b1);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Send the first nbits of a frame; glitch_bit inserts a 3-cycle low pulse
  // in the high phase before that bit's falling edge.
  task automatic send_bits(input logic [10:0] fr, input int nbits, input int glitch_bit);
    for (int i = 0; i < nbits; i++) begin
      bus.DATA_MOUSE_IN = fr[i];
      if (i == glitch_bit) begin
        cyc(6);
        bus.CLK_MOUSE_IN = 1'b0;
        cyc(3);
        bus.CLK_MOUSE_IN = 1'b1;
        cyc(HP - 9);
      end else begin
        cyc(HP);
      end
      bus.CLK_MOUSE_IN = 1'b0;
      cyc(HP);
      bus.CLK_MOUSE_IN = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stp,
                            input int glitch_bit);
    logic [10:0] fr;
    fr = {stp, par, b, 1'b0};
    send_bits(fr, 11, glitch_bit);
    bus.DATA_MOUSE_IN = 1'b1;
    cyc(3 * HP);
  endtask

  task automatic test_reset;
    bus.CLK_MOUSE_IN  = 1'b1;
    bus.DATA_MOUSE_IN = 1'b1;
    bus.READ_ENABLE   = 1'b1;
    rst_n = 1'b0;
    cyc(3);
    checks++; if (bus.BYTE_READY !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", bus.BYTE_READY); end
    checks++; if (bus.BYTE_READ !== 8'h00) begin failures++; $display("FAIL reset_byte got=%h exp=00", bus.BYTE_READ); end
    checks++; if (bus.BYTE_ERROR_CODE !== 2'b00) begin failures++; $display("FAIL reset_err got=%b exp=00", bus.BYTE_ERROR_CODE); end
    rst_n = 1'b1;
    cyc(20);
    checks++; if (bus.BYTE_READY !== 1'b0) begin failures++; $display("FAIL post_reset_ready got=%b exp=0", bus.BYTE_READY); end
    checks++; if (bus.BYTE_READ !== 8'h00) begin failures++; $display("FAIL post_reset_byte got=%h exp=00", bus.BYTE_READ); end
    checks++; if (ready_cnt !== 0) begin failures++; $display("FAIL post_reset_pulses got=%0d exp=0", ready_cnt); end
  endtask

  task automatic test_valid_frame;
    int r0;
    r0 = ready_cnt;
    send_frame(8'hFA, 1'b1, 1'b1, -1);
    checks++; if (ready_cnt - r0 !== 1) begin failures++; $display("FAIL valid_pulses got=%0d exp=1", ready_cnt - r0); end
    checks++; if (bus.BYTE_READ !== 8'hFA) begin failures++; $display("FAIL valid_byte got=%h exp=fa", bus.BYTE_READ); end
    checks++; if (bus.BYTE_ERROR_CODE !== 2'b00) begin failures++; $display("FAIL valid_err got=%b exp=00", bus.BYTE_ERROR_CODE); end
  endtask

  task automatic test_errors;
    int r0;
    r0 = ready_cnt;
    send_frame(8'hAA, 1'b0, 1'b1, -1);
    checks++; if (ready_cnt - r0 !== 1) begin failures++; $display("FAIL par_pulses got=%0d exp=1", ready_cnt - r0); end
    checks++; if (bus.BYTE_READ !== 8'hAA) begin failures++; $display("FAIL par_byte got=%h exp=aa", bus.BYTE_READ); end
    checks++; if (bus.BYTE_ERROR_CODE !== 2'b01) begin failures++; $display("FAIL par_err got=%b exp=01", bus.BYTE_ERROR_CODE); end
    r0 = ready_cnt;
    send_frame(8'h08, 1'b0, 1'b0, -1);
    checks++; if (ready_cnt - r0 !== 1) begin failures++; $display("FAIL stop_pulses got=%0d exp=1", ready_cnt - r0); end
    checks++; if (bus.BYTE_READ !== 8'h08) begin failures++; $display("FAIL stop_byte got=%h exp=08", bus.BYTE_READ); end
    checks++; if (bus.BYTE_ERROR_CODE !== 2'b10) begin failures++; $display("FAIL stop_err got=%b exp=10", bus.BYTE_ERROR_CODE); end
  endtask

  task automatic test_timeout;
    int r0;
    logic [10:0] fr;
    r0 = ready_cnt;
    fr = {1'b1, 1'b1, 8'h3C, 1'b0};
    send_bits(fr, 5, -1);
    bus.DATA_MOUSE_IN = 1'b1;
    cyc(TOUT + 100);
    checks++; if (ready_cnt - r0 !== 0) begin failures++; $display("FAIL to_pulses got=%0d exp=0", ready_cnt - r0); end
    checks++; if (bus.BYTE_READ !== 8'h08) begin failures++; $display("FAIL to_byte_held got=%h exp=08", bus.BYTE_READ); end
    checks++; if (bus.BYTE_ERROR_CODE !== 2'b10) begin failures++; $display("FAIL to_err_held got=%b exp=10", bus.BYTE_ERROR_CODE); end
    r0 = ready_cnt;
    send_frame(8'hF4, 1'b0, 1'b1, -1);
    checks++; if (ready_cnt - r0 !== 1) begin failures++; $display("FAIL to_next_pulses got=%0d exp=1", ready_cnt - r0); end
    checks++; if (bus.BYTE_READ !== 8'hF4) begin failures++; $display("FAIL to_next_byte got=%h exp=f4", bus.BYTE_READ); end
    checks++; if (bus.BYTE_ERROR_CODE !== 2'b00) begin failures++; $display("FAIL to_next_err got=%b exp=00", bus.BYTE_ERROR_CODE); end
  endtask

  task automatic test_read_enable;
    int r0;
    logic [10:0] fr;
    r0 = ready_cnt;
    fr = {1'b1, 1'b1, 8'h66, 1'b0};
    send_bits(fr, 4, -1);
    bus.READ_ENABLE = 1'b0;
    cyc(5);
    bus.READ_ENABLE = 1'b1;
    send_bits(fr >> 4, 7, -1);
    bus.DATA_MOUSE_IN = 1'b1;
    // Any stray frame started by a mid-frame zero expires here.
    cyc(TOUT + 100);
    checks++; if (ready_cnt - r0 !== 0) begin failures++; $display("FAIL re_pulses got=%0d exp=0", ready_cnt - r0); end
    checks++; if (bus.BYTE_READ !== 8'hF4) begin failures++; $display("FAIL re_byte_held got=%h exp=f4", bus.BYTE_READ); end
    r0 = ready_cnt;
    send_frame(8'hC3, 1'b1, 1'b1, -1);
    checks++; if (ready_cnt - r0 !== 1) begin failures++; $display("FAIL re_next_pulses got=%0d exp=1", ready_cnt - r0); end
    checks++; if (bus.BYTE_READ !== 8'hC3) begin failures++; $display("FAIL re_next_byte got=%h exp=c3", bus.BYTE_READ); end
    checks++; if (bus.BYTE_ERROR_CODE !== 2'b00) begin failures++; $display("FAIL re_next_err got=%b exp=00", bus.BYTE_ERROR_CODE); end
  endtask

  task automatic test_glitch;
    int r0;
    r0 = ready_cnt;
    bus.CLK_MOUSE_IN = 1'b0;
    cyc(3);
    bus.CLK_MOUSE_IN = 1'b1;
    cyc(HP);
    send_frame(8'h5A, 1'b1, 1'b1, 4);
    checks++; if (ready_cnt - r0 !== 1) begin failures++; $display("FAIL glitch_pulses got=%0d exp=1", ready_cnt - r0); end
    checks++; if (bus.BYTE_READ !== 8'h5A) begin failures++; $display("FAIL glitch_byte got=%h exp=5a", bus.BYTE_READ); end
    checks++; if (bus.BYTE_ERROR_CODE !== 2'b00) begin failures++; $display("FAIL glitch_err got=%b exp=00", bus.BYTE_ERROR_CODE); end
  endtask

  task automatic test_async_reset;
    int r0;
    logic [10:0] fr;
    bus.READ_ENABLE = 1'b1;
    fr = {1'b1, 1'b0, 8'h07, 1'b0};
    send_bits(fr, 5, -1);
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.BYTE_READY !== 1'b0) begin failures++; $display("FAIL arst_ready got=%b exp=0", bus.BYTE_READY); end
    checks++; if (bus.BYTE_READ !== 8'h00) begin failures++; $display("FAIL arst_byte got=%h exp=00", bus.BYTE_READ); end
    checks++; if (bus.BYTE_ERROR_CODE !== 2'b00) begin failures++; $display("FAIL arst_err got=%b exp=00", bus.BYTE_ERROR_CODE); end
    bus.CLK_MOUSE_IN  = 1'b1;
    bus.DATA_MOUSE_IN = 1'b1;
    cyc(3);
    rst_n = 1'b1;
    cyc(20);
    r0 = ready_cnt;
    send_frame(8'hFA, 1'b1, 1'b1, -1);
    checks++; if (ready_cnt - r0 !== 1) begin failures++; $display("FAIL arst_next_pulses got=%0d exp=1", ready_cnt - r0); end
    checks++; if (bus.BYTE_READ !== 8'hFA) begin failures++; $display("FAIL arst_next_byte got=%h exp=fa", bus.BYTE_READ); end
    checks++; if (bus.BYTE_ERROR_CODE !== 2'b00) begin failures++; $display("FAIL arst_next_err got=%b exp=00", bus.BYTE_ERROR_CODE); end
  endtask

  task automatic test_back_to_back;
    int r0;
    logic [10:0] fr;
    r0 = ready_cnt;
    fr = {1'b1, 1'b1, 8'h11, 1'b0};
    send_bits(fr, 11, -1);
    bus.DATA_MOUSE_IN = 1'b1;
    cyc(HP);
    send_frame(8'hE7, 1'b1, 1'b1, -1);
    checks++; if (ready_cnt - r0 !== 2) begin failures++; $display("FAIL b2b_pulses got=%0d exp=2", ready_cnt - r0); end
    checks++; if (bus.BYTE_READ !== 8'hE7) begin failures++; $display("FAIL b2b_byte got=%h exp=e7", bus.BYTE_READ); end
    checks++; if (bus.BYTE_ERROR_CODE !== 2'b00) begin failures++; $display("FAIL b2b_err got=%b exp=00", bus.BYTE_ERROR_CODE); end
    checks++; if (consec !== 0) begin failures++; $display("FAIL consecutive_ready got=%0d exp=0", consec); end
  endtask

  initial begin
    test_reset;
    test_valid_frame;
    test_errors;
    test_timeout;
    test_read_enable;
    test_glitch;
    test_async_reset;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
